// File: rtl/bit_reorder_pipe.sv
// bit_reorder_pipe: per-lane bit transform (pass/reverse/rotate/lane-swap)
// followed by a DEPTH-stage valid/ready register pipeline with backpressure.
module bit_reorder_pipe #(
    parameter int W     = 8,
    parameter int LANES = 2,
    parameter int DEPTH = 3
) (
    input  logic                   clock,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_mode,
    input  logic [$clog2(W)-1:0]   in_rot,
    input  logic [W*LANES-1:0]     in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W*LANES-1:0]     out_data,
    output logic                   busy
);
    localparam int BW = W * LANES;

    logic [BW-1:0]    xf;
    logic [W-1:0]     lane_x, lane_r;
    logic [2*W-1:0]   dbl;
    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] v_q, v_d;
    logic [BW-1:0]    d_q [DEPTH];
    logic [BW-1:0]    d_d [DEPTH];

    // Rotation takes the upper half of the lane doubled and shifted left.
    always_comb begin
        xf     = '0;
        lane_x = '0;
        lane_r = '0;
        dbl    = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_x = in_data[k*W +: W];
            dbl    = {lane_x, lane_x} << (int'(in_rot) % W);
            for (int i = 0; i < W; i++)
                lane_r[i] = lane_x[W-1-i];
            xf[k*W +: W] = in_mode == 2'd0 ? lane_x :
                           in_mode == 2'd1 ? lane_r :
                           in_mode == 2'd2 ? dbl[2*W-1 -: W] :
                                             in_data[(LANES-1-k)*W +: W];
        end
    end

    always_comb begin
        rdy[DEPTH] = out_ready;
        for (int s = DEPTH - 1; s >= 0; s--)
            rdy[s] = !v_q[s] | rdy[s+1];
        v_d = v_q;
        d_d = d_q;
        if (rdy[0]) begin
            v_d[0] = in_valid;
            d_d[0] = xf;
        end
        for (int s = 1; s < DEPTH; s++) begin
            if (rdy[s]) begin
                v_d[s] = v_q[s-1];
                d_d[s] = d_q[s-1];
            end
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            v_q <= '0;
            for (int s = 0; s < DEPTH; s++)
                d_q[s] <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign busy      = |v_q;
endmodule

// File: tb/tb_bit_reorder_pipe.sv
// tb_bit_reorder_pipe: directed vector table, backpressure and reset
// sequences, and a randomized stream scored against a reference queue.
module tb_bit_reorder_pipe;
    logic        clock = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_mode = 2'd0;
    logic [2:0]  in_rot = 3'd0;
    logic [15:0] in_data = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    bit          hold_pend = 0;
    logic [15:0] hold_data;
    bit          prod_done = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [2:0]  rot;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[8];

    always #5 clock = ~clock;

    bit_reorder_pipe #(.W(8), .LANES(2), .DEPTH(3)) dut (
        .clock(clock), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_rot(in_rot), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    function automatic logic [15:0] model(input logic [1:0] m, input logic [2:0] r,
                                          input logic [15:0] x);
        int lane[2];
        int o[2];
        int rr;
        lane[0] = int'(x[7:0]);
        lane[1] = int'(x[15:8]);
        rr = int'(r) % 8;
        for (int k = 0; k < 2; k++) begin
            o[k] = 0;
            if (m == 2'd0) o[k] = lane[k];
            else if (m == 2'd1) begin
                for (int i = 0; i < 8; i++)
                    if ((lane[k] / (2 ** i)) % 2 == 1) o[k] += 2 ** (7 - i);
            end else if (m == 2'd2) o[k] = (lane[k] * (2 ** rr)) % 256 + lane[k] / (2 ** (8 - rr));
            else o[k] = lane[1-k];
        end
        return {o[1][7:0], o[0][7:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    always @(negedge clock) begin
        if (rstn) begin
            if (hold_pend) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(hold_data));
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
                else check("order_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_mode, in_rot, in_data));
        end
    end

    task automatic send(input logic [1:0] m, input logic [2:0] r, input logic [15:0] d);
        int n;
        in_valid = 1'b1;
        in_mode  = m;
        in_rot   = r;
        in_data  = d;
        for (n = 0; n < 200; n++) begin
            @(negedge clock);
            if (in_ready) break;
        end
        if (n == 200) check("send_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = v.mode;
        in_rot    = v.rot;
        in_data   = v.data;
        @(negedge clock);
        check("vec_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        check("vec_lat1", 32'(out_valid), 32'd0);
        @(negedge clock);
        check("vec_lat2", 32'(out_valid), 32'd0);
        @(negedge clock);
        check("vec_lat3_valid", 32'(out_valid), 32'd1);
        check("vec_data", 32'(out_data), 32'(v.exp));
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        for (n = 0; n < 100 && busy; n++) begin
            @(posedge clock);
            #1;
        end
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bp[5];
        vecs[0] = '{2'd1, 3'd0, 16'h0180, 16'h8001};
        vecs[1] = '{2'd2, 3'd3, 16'h0181, 16'h080C};
        vecs[2] = '{2'd2, 3'd0, 16'h0181, 16'h0181};
        vecs[3] = '{2'd3, 3'd0, 16'hA55A, 16'h5AA5};
        vecs[4] = '{2'd0, 3'd0, 16'h1234, 16'h1234};
        vecs[5] = '{2'd1, 3'd0, 16'h0F01, 16'hF080};
        vecs[6] = '{2'd2, 3'd7, 16'h0102, 16'h8001};
        vecs[7] = '{2'd3, 3'd5, 16'h1234, 16'h3412};

        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        rstn = 1'b1;
        @(posedge clock);
        #1 check("idle_in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) apply(vecs[i]);

        for (int i = 0; i < 5; i++) bp[i] = 16'($urandom);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(2'(i), 3'(i + 1), bp[i]);
        in_valid = 1'b1;
        in_mode  = 2'd3;
        in_rot   = 3'd4;
        in_data  = bp[3];
        repeat (4) begin
            @(negedge clock);
            check("full_in_ready", 32'(in_ready), 32'd0);
            check("full_out_data", 32'(out_data), 32'(model(2'd0, 3'd1, bp[0])));
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        send(2'd3, 3'd4, bp[3]);
        send(2'd1, 3'd0, bp[4]);
        drain();

        out_ready = 1'b0;
        send(2'd1, 3'd0, 16'hBEEF);
        send(2'd2, 3'd5, 16'hCAFE);
        in_valid = 1'b1;
        @(negedge clock);
        #2 rstn = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        exp_q.delete();
        hold_pend = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1 rstn = 1'b1;
        apply(vecs[1]);

        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clock);
                        #1;
                    end
                    send(2'($urandom), 3'($urandom), 16'($urandom));
                end
                prod_done = 1;
            end
            begin
                for (int n = 0; n < 20000 && !prod_done; n++) begin
                    @(posedge clock);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                check("random_finish", 32'(prod_done), 32'd1);
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
